// File: rtl/clause_seq_ctrl_pkg.sv
// Shared definitions for the clause sequencer and the class-sum controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clause_seq_ctrl_pkg;

    // Sequencer states; the 3-bit encoding is shared with the class-sum controller.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4,
        S_CAPT  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    // Chain plus PE pipeline depth: cycles after the last beat before clause_op settles.
    localparam int DRAIN_CYC_DEF = 4;

    // Number of PE lanes driven by pe_en.
    localparam int PE_W = 8;

endpackage

// File: rtl/clause_seq_ctrl_beat_counter.sv
// Up-counter from 0 to a loaded terminal value, saturating at all-ones; tc flags the terminal count.
// Latency: load takes effect on the next clock; tc is decoded from the count register.
// Backpressure: none; en simply stalls the count.
module clause_seq_ctrl_beat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] term_q;
    logic [W-1:0] term_d;

    // Load restarts the count at 0 with a new terminal value; otherwise count up and hold at max.
    always_comb begin
        cnt_d  = cnt_q;
        term_d = term_q;
        if (load) begin
            cnt_d  = '0;
            term_d = load_val;
        end else if (en && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count and terminal registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            term_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            term_q <= term_d;
        end
    end

    assign tc = (cnt_q == term_q);

endmodule

// File: rtl/clause_seq_ctrl.sv
// Walks all clauses of one image through the conv_arch chain: fetch, load, sweep, drain, capture.
// Latency: (2 + sweep_len + DRAIN_CYC + 1) cycles per clause, plus 1 DONE cycle per image.
// Backpressure: none; start while busy is dropped, abort returns to IDLE on the next cycle.
module clause_seq_ctrl
    import clause_seq_ctrl_pkg::*;
#(
    parameter int CLAUSEN   = 10,
    parameter int CW        = 256,
    parameter int SWEEP_W   = 16,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF,
    parameter int AW        = $clog2(CLAUSEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [SWEEP_W-1:0] sweep_len,
    input  logic [PE_W-1:0]    pe_en_cfg,
    output logic               clause_rd_en,
    output logic [AW-1:0]      clause_rd_addr,
    input  logic [CW-1:0]      clause_rd_data,
    output logic [CW-1:0]      clause_write,
    output logic               valid,
    output logic               clause_act,
    output logic               img_rst,
    output logic [PE_W-1:0]    pe_en,
    output logic               feed_en,
    input  logic               clause_op_in,
    output logic [CLAUSEN-1:0] clause_vec,
    output logic               vec_valid,
    output logic               busy
);

    localparam logic [AW-1:0]      LAST_IDX   = AW'(CLAUSEN - 1);
    localparam logic [SWEEP_W-1:0] DRAIN_TERM = SWEEP_W'(DRAIN_CYC - 1);

    state_t state_q;
    state_t state_d;

    logic [AW-1:0]      idx_q,        idx_d;
    logic [SWEEP_W-1:0] sweep_len_q,  sweep_len_d;
    logic [PE_W-1:0]    pe_cfg_q,     pe_cfg_d;

    logic               clause_rd_en_q,   clause_rd_en_d;
    logic [AW-1:0]      clause_rd_addr_q, clause_rd_addr_d;
    logic [CW-1:0]      clause_write_q,   clause_write_d;
    logic               valid_q,          valid_d;
    logic               clause_act_q,     clause_act_d;
    logic               img_rst_q,        img_rst_d;
    logic [PE_W-1:0]    pe_en_q,          pe_en_d;
    logic               feed_en_q,        feed_en_d;
    logic [CLAUSEN-1:0] clause_vec_q,     clause_vec_d;
    logic               vec_valid_q,      vec_valid_d;
    logic               busy_q,           busy_d;

    logic               cnt_load;
    logic [SWEEP_W-1:0] cnt_load_val;
    logic               cnt_en;
    logic               cnt_tc;

    logic sweep_zero;
    logic abort_hit;
    logic start_hit;

    assign sweep_zero = (sweep_len_q == '0);
    assign abort_hit  = abort && (state_q != S_IDLE);
    assign start_hit  = start && (state_q == S_IDLE);

    // One counter serves both the RUN beat count and the DRAIN wait.
    clause_seq_ctrl_beat_counter #(
        .W (SWEEP_W)
    ) u_beat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .tc       (cnt_tc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and counter control; abort overrides every transition.
    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_en       = 1'b0;
        if (abort_hit) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    state_d = S_LOAD;
                end
                S_LOAD: begin
                    // An empty sweep goes straight to DRAIN so the chain timing stays uniform.
                    cnt_load = 1'b1;
                    if (sweep_zero) begin
                        state_d      = S_DRAIN;
                        cnt_load_val = DRAIN_TERM;
                    end else begin
                        state_d      = S_RUN;
                        cnt_load_val = sweep_len_q - SWEEP_W'(1);
                    end
                end
                S_RUN: begin
                    if (cnt_tc) begin
                        state_d      = S_DRAIN;
                        cnt_load     = 1'b1;
                        cnt_load_val = DRAIN_TERM;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (cnt_tc) begin
                        state_d = S_CAPT;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                S_CAPT: begin
                    state_d = (idx_q == LAST_IDX) ? S_DONE : S_FETCH;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output and datapath next values; outputs are decoded from the next state so they line up with it.
    always_comb begin
        idx_d          = idx_q;
        sweep_len_d    = sweep_len_q;
        pe_cfg_d       = pe_cfg_q;
        clause_vec_d   = clause_vec_q;
        clause_write_d = clause_write_q;

        if (start_hit) begin
            idx_d        = '0;
            sweep_len_d  = sweep_len;
            pe_cfg_d     = pe_en_cfg;
            clause_vec_d = '0;
        end

        if ((state_q == S_CAPT) && !abort) begin
            clause_vec_d[idx_q] = clause_op_in & ~sweep_zero;
            if (idx_q != LAST_IDX) begin
                idx_d = idx_q + AW'(1);
            end
        end

        // Memory data is valid during LOAD, so the registered word and its strobe appear together next cycle.
        if ((state_q == S_LOAD) && !abort) begin
            clause_write_d = clause_rd_data;
        end
        valid_d = (state_q == S_LOAD) && !abort;

        clause_rd_en_d   = (state_d == S_FETCH);
        clause_rd_addr_d = (state_d == S_FETCH) ? idx_d : clause_rd_addr_q;
        clause_act_d     = (state_d == S_RUN) || (state_d == S_DRAIN);
        feed_en_d        = (state_d == S_RUN);
        pe_en_d          = clause_act_d ? pe_cfg_q : '0;
        img_rst_d        = start_hit || abort_hit || (state_d == S_CAPT);
        vec_valid_d      = (state_d == S_DONE);
        busy_d           = (state_d != S_IDLE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q            <= '0;
            sweep_len_q      <= '0;
            pe_cfg_q         <= '0;
            clause_rd_en_q   <= 1'b0;
            clause_rd_addr_q <= '0;
            clause_write_q   <= '0;
            valid_q          <= 1'b0;
            clause_act_q     <= 1'b0;
            img_rst_q        <= 1'b0;
            pe_en_q          <= '0;
            feed_en_q        <= 1'b0;
            clause_vec_q     <= '0;
            vec_valid_q      <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            idx_q            <= idx_d;
            sweep_len_q      <= sweep_len_d;
            pe_cfg_q         <= pe_cfg_d;
            clause_rd_en_q   <= clause_rd_en_d;
            clause_rd_addr_q <= clause_rd_addr_d;
            clause_write_q   <= clause_write_d;
            valid_q          <= valid_d;
            clause_act_q     <= clause_act_d;
            img_rst_q        <= img_rst_d;
            pe_en_q          <= pe_en_d;
            feed_en_q        <= feed_en_d;
            clause_vec_q     <= clause_vec_d;
            vec_valid_q      <= vec_valid_d;
            busy_q           <= busy_d;
        end
    end

    assign clause_rd_en   = clause_rd_en_q;
    assign clause_rd_addr = clause_rd_addr_q;
    assign clause_write   = clause_write_q;
    assign valid          = valid_q;
    assign clause_act     = clause_act_q;
    assign img_rst        = img_rst_q;
    assign pe_en          = pe_en_q;
    assign feed_en        = feed_en_q;
    assign clause_vec     = clause_vec_q;
    assign vec_valid      = vec_valid_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_clause_seq_ctrl.sv
// Directed bench for clause_seq_ctrl with a clause memory model and a one-stage chain model.
// Latency: cycle counts are taken from the cycle start is high to the cycle vec_valid is high.
// Backpressure: n/a.
module tb_clause_seq_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [15:0]  sweep_len = 16'd0;
    logic [7:0]   pe_en_cfg = 8'd0;
    logic         clause_rd_en;
    logic [3:0]   clause_rd_addr;
    logic [255:0] clause_rd_data = '0;
    logic [255:0] clause_write;
    logic         valid;
    logic         clause_act;
    logic         img_rst;
    logic [7:0]   pe_en;
    logic         feed_en;
    logic         clause_op_in;
    logic [9:0]   clause_vec;
    logic         vec_valid;
    logic         busy;

    int n_chk = 0;
    int n_err = 0;

    // Monitor tallies.
    int n_valid, n_feed, n_act, n_vv, n_img, n_rd;
    int bad_word, bad_addr, bad_pe;
    int exp_widx, exp_raddr;
    logic [7:0] exp_pe = 8'h00;

    // Chain model state.
    logic [15:0] op_mask = 16'hFFFF;
    logic [3:0]  chain_key = 4'd0;

    clause_seq_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .sweep_len      (sweep_len),
        .pe_en_cfg      (pe_en_cfg),
        .clause_rd_en   (clause_rd_en),
        .clause_rd_addr (clause_rd_addr),
        .clause_rd_data (clause_rd_data),
        .clause_write   (clause_write),
        .valid          (valid),
        .clause_act     (clause_act),
        .img_rst        (img_rst),
        .pe_en          (pe_en),
        .feed_en        (feed_en),
        .clause_op_in   (clause_op_in),
        .clause_vec     (clause_vec),
        .vec_valid      (vec_valid),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] word_of(input int i);
        logic [3:0] k;
        k = i[3:0];
        return {8{28'hC0DE123, k}};
    endfunction

    // Clause memory: one-cycle read latency.
    always @(posedge clk) begin
        if (clause_rd_en) clause_rd_data <= word_of(int'(clause_rd_addr));
    end

    // Chain model: remembers which clause was loaded and answers from op_mask.
    always @(posedge clk) begin
        if (valid) chain_key <= clause_write[3:0];
    end
    assign clause_op_in = op_mask[chain_key];

    // Output monitor sampled away from the active edge.
    always @(negedge clk) begin
        if (valid) begin
            n_valid++;
            if (clause_write !== word_of(exp_widx)) bad_word++;
            exp_widx++;
        end
        if (clause_rd_en) begin
            n_rd++;
            if (clause_rd_addr !== 4'(exp_raddr)) bad_addr++;
            exp_raddr++;
        end
        if (feed_en) n_feed++;
        if (clause_act) n_act++;
        if (vec_valid) n_vv++;
        if (img_rst) n_img++;
        if (pe_en !== (clause_act ? exp_pe : 8'h00)) bad_pe++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        @(posedge clk);
        #1;
        n_valid = 0; n_feed = 0; n_act = 0; n_vv = 0; n_img = 0; n_rd = 0;
        bad_word = 0; bad_addr = 0; bad_pe = 0; exp_widx = 0; exp_raddr = 0;
    endtask

    // Pulse start, then scramble the sampled inputs; optionally re-pulse start at poke_at.
    // Returns on the vec_valid cycle or when lat reaches stop_at.
    task automatic run_image(input logic [15:0] sl, input logic [7:0] cfg,
                             input int poke_at, input int stop_at, output int lat);
        @(negedge clk);
        sweep_len = sl;
        pe_en_cfg = cfg;
        exp_pe    = cfg;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        sweep_len = sl + 16'd3;
        pe_en_cfg = ~cfg;
        lat = 1;
        while (!vec_valid && lat < stop_at) begin
            start = (lat == poke_at);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        // Reset state.
        #12;
        chk("rst_ctl", 32'({clause_rd_en, clause_rd_addr, valid, clause_act, img_rst,
                            pe_en, feed_en, vec_valid, busy}), 32'h0);
        chk("rst_vec", 32'(clause_vec), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'h0);

        // All clauses true, sweep of 5.
        op_mask = 16'hFFFF;
        clr_mon();
        run_image(16'd5, 8'hA5, 0, 1000, lat);
        chk("t1_lat", 32'(lat), 32'd121);
        chk("t1_vv", 32'(vec_valid), 32'h1);
        chk("t1_vec", 32'(clause_vec), 32'h3FF);
        @(negedge clk);
        chk("t1_busy_after", 32'(busy), 32'h0);
        chk("t1_vec_hold", 32'(clause_vec), 32'h3FF);
        chk("t1_nvalid", 32'(n_valid), 32'd10);
        chk("t1_badword", 32'(bad_word), 32'd0);
        chk("t1_nrd", 32'(n_rd), 32'd10);
        chk("t1_badaddr", 32'(bad_addr), 32'd0);
        chk("t1_nfeed", 32'(n_feed), 32'd50);
        chk("t1_nact", 32'(n_act), 32'd90);
        chk("t1_nvv", 32'(n_vv), 32'd1);
        chk("t1_nimg", 32'(n_img), 32'd11);
        chk("t1_badpe", 32'(bad_pe), 32'd0);

        // Only clauses 3 and 9 true.
        op_mask = 16'h0208;
        clr_mon();
        run_image(16'd5, 8'h3C, 0, 1000, lat);
        chk("t2_lat", 32'(lat), 32'd121);
        @(negedge clk);
        chk("t2_vec", 32'(clause_vec), 32'h208);
        chk("t2_nvalid", 32'(n_valid), 32'd10);
        chk("t2_badword", 32'(bad_word), 32'd0);
        chk("t2_badaddr", 32'(bad_addr), 32'd0);

        // Empty sweep: result bits forced 0 even though the chain answers 1.
        op_mask = 16'hFFFF;
        clr_mon();
        run_image(16'd0, 8'hA5, 0, 1000, lat);
        chk("t3_lat", 32'(lat), 32'd71);
        @(negedge clk);
        chk("t3_vec", 32'(clause_vec), 32'h0);
        chk("t3_nfeed", 32'(n_feed), 32'd0);
        chk("t3_nact", 32'(n_act), 32'd40);
        chk("t3_nvalid", 32'(n_valid), 32'd10);

        // Abort in the RUN of clause 4 (RUN occupies cycles 51..55).
        clr_mon();
        run_image(16'd5, 8'hA5, 0, 52, lat);
        chk("t4_in_run", 32'({clause_act, feed_en}), 32'h3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t4_busy", 32'(busy), 32'h0);
        chk("t4_imgrst", 32'(img_rst), 32'h1);
        chk("t4_act", 32'({clause_act, feed_en, valid}), 32'h0);
        chk("t4_vec", 32'(clause_vec), 32'h00F);
        @(negedge clk);
        chk("t4_imgrst_off", 32'(img_rst), 32'h0);
        repeat (150) @(negedge clk);
        chk("t4_nvv", 32'(n_vv), 32'd0);
        chk("t4_nimg", 32'(n_img), 32'd6);
        chk("t4_vec_hold", 32'(clause_vec), 32'h00F);

        // start re-pulsed mid-image is ignored.
        clr_mon();
        run_image(16'd5, 8'h5A, 30, 1000, lat);
        chk("t5_lat", 32'(lat), 32'd121);
        @(negedge clk);
        chk("t5_vec", 32'(clause_vec), 32'h3FF);
        chk("t5_nimg", 32'(n_img), 32'd11);
        chk("t5_nvalid", 32'(n_valid), 32'd10);
        chk("t5_badpe", 32'(bad_pe), 32'd0);

        // Async reset in the DRAIN of clause 0 (DRAIN occupies cycles 8..11).
        clr_mon();
        run_image(16'd5, 8'h5A, 0, 9, lat);
        chk("t6_in_drain", 32'({clause_act, feed_en, pe_en}), 32'h25A);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ctl", 32'({clause_rd_en, clause_rd_addr, valid, clause_act, img_rst,
                               pe_en, feed_en, vec_valid, busy}), 32'h0);
        chk("t6_rst_cw", 32'(clause_write != '0), 32'h0);
        chk("t6_rst_vec", 32'(clause_vec), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
